turn_launcher: RTL and testbench

- Turn-and-fire controller that drives the projectile block's launch interface: `launch`, `launchX`, `launchY`, `angle` and `power`.
- Holds per-player aim state (angle, power) and steps it from debounced button inputs.
- Issues one frame-aligned launch pulse, then tracks the projectile's `exploded` flag through flight and a settle period before handing the turn to the other player.
- Sits between the keyboard/button decode and the projectile block in the game top level.

---
 rtl/game_pkg.sv | 36 +++
 rtl/aim_stepper.sv | 101 ++++++++++
 rtl/turn_launcher.sv | 233 +++++++++++++++++++++++
 tb/tb_turn_launcher.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the turn/fire controller.
//   state_t   : controller phase (AIM, LAUNCH, ARM, FLIGHT, SETTLE)
//   *_MAX     : aim value saturation limits
//   P*_ANGLE / P*_POWER : per-player aim values after reset
//   sat_step  : one saturating up/down step of a 4-bit aim value
package game_pkg;

  typedef enum logic [2:0] {
    AIM,
    LAUNCH,
    ARM,
    FLIGHT,
    SETTLE
  } state_t;

  localparam logic [3:0] ANGLE_MAX = 4'd8;
  localparam logic [3:0] POWER_MAX = 4'd7;

  localparam logic [3:0] P0_ANGLE = 4'd2;
  localparam logic [3:0] P1_ANGLE = 4'd6;
  localparam logic [3:0] P0_POWER = 4'd4;
  localparam logic [3:0] P1_POWER = 4'd4;

  // Opposing requests cancel; otherwise step by one and clamp to [0, max].
  function automatic logic [3:0] sat_step(input logic [3:0] cur,
                                          input logic [3:0] max,
                                          input logic       inc,
                                          input logic       dec);
    logic [3:0] res;
    res = cur;
    if (inc && !dec && (cur < max)) res = cur + 4'd1;
    if (dec && !inc && (cur != 4'd0)) res = cur - 4'd1;
    return res;
  endfunction

endpackage

// File: rtl/aim_stepper.sv
// aim_stepper: button edge / auto-repeat logic for one aim quantity.
// A press steps the value on the next tick; while held it steps again every
// REPEAT_FRAMES ticks. The value register itself lives in the parent (one per
// player); this block returns the saturated next value and a load strobe.
// Ports:
//   clk, reset      : clock, async active-high reset
//   i_up, i_dn      : button levels
//   i_tick          : 1-clk frame pulse
//   i_en            : stepping allowed (AIM); low discards pending edges
//   i_max           : saturation limit
//   i_cur           : current value of the active player
//   o_load, o_next  : write strobe and value for the active player's register
module aim_stepper
  import game_pkg::*;
#(
  parameter int unsigned REPEAT_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_up,
  input  logic       i_dn,
  input  logic       i_tick,
  input  logic       i_en,
  input  logic [3:0] i_max,
  input  logic [3:0] i_cur,
  output logic       o_load,
  output logic [3:0] o_next
);

  localparam int unsigned RW = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;

  logic          r_up_q;
  logic          r_dn_q;
  logic          r_pend_up;
  logic          r_pend_dn;
  logic          r_armed;
  logic [RW-1:0] r_rcnt;

  logic w_up_edge;
  logic w_dn_edge;
  logic w_held;
  logic w_pend;
  logic w_rep_hit;
  logic w_rep;
  logic w_step_up;
  logic w_step_dn;

  assign w_up_edge = i_up & ~r_up_q;
  assign w_dn_edge = i_dn & ~r_dn_q;
  assign w_held    = i_up | i_dn;
  assign w_pend    = r_pend_up | r_pend_dn;
  assign w_rep_hit = (r_rcnt == RW'(REPEAT_FRAMES - 1));
  // Repeat only after the initial press step has been taken (r_armed).
  assign w_rep     = i_tick & r_armed & w_held & ~w_pend & w_rep_hit;
  assign w_step_up = i_en & i_tick & (r_pend_up | (w_rep & i_up));
  assign w_step_dn = i_en & i_tick & (r_pend_dn | (w_rep & i_dn));

  assign o_next = sat_step(i_cur, i_max, w_step_up, w_step_dn);
  assign o_load = w_step_up ^ w_step_dn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_up_q    <= 1'b0;
      r_dn_q    <= 1'b0;
      r_pend_up <= 1'b0;
      r_pend_dn <= 1'b0;
      r_armed   <= 1'b0;
      r_rcnt    <= '0;
    end else begin
      // Level history keeps updating while disabled so a button held across
      // a busy period does not produce a fresh edge afterwards.
      r_up_q <= i_up;
      r_dn_q <= i_dn;
      if (!i_en) begin
        r_pend_up <= 1'b0;
        r_pend_dn <= 1'b0;
        r_armed   <= 1'b0;
        r_rcnt    <= '0;
      end else begin
        if (i_tick) begin
          r_pend_up <= w_up_edge;
          r_pend_dn <= w_dn_edge;
          if (w_pend) begin
            r_armed <= 1'b1;
            r_rcnt  <= '0;
          end else if (r_armed && w_held) begin
            r_rcnt <= w_rep_hit ? '0 : r_rcnt + 1'b1;
          end
        end else begin
          r_pend_up <= r_pend_up | w_up_edge;
          r_pend_dn <= r_pend_dn | w_dn_edge;
        end
        if (!w_held) begin
          r_armed <= 1'b0;
          r_rcnt  <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/turn_launcher.sv
// turn_launcher: turn-and-fire controller driving the projectile launch port.
// Holds per-player angle/power, steps them from buttons in AIM, fires one
// frame-aligned launch pulse, follows `exploded` through flight and a settle
// period, then swaps the active player.
// Optional macro TURN_TIMER_EN: per-turn countdown with auto-fire at zero;
// without it `timer` is tied to 0.
// Ports:
//   clk, reset                 : clock, async active-high reset
//   frame_clk                  : raw frame tick (synchronised internally)
//   fire, ang_up/dn, pow_up/dn : button levels
//   tankX0/Y0, tankX1/Y1       : tank positions
//   exploded                   : projectile exploded/idle flag
//   launch, launchX, launchY   : launch request and origin
//   angle, power, turn, busy   : active player aim, player index, not-in-AIM
//   timer                      : frames left in turn (feature only)
module turn_launcher
  import game_pkg::*;
#(
  parameter int unsigned REPEAT_FRAMES = 8,
  parameter int unsigned ARM_TIMEOUT   = 4,
  parameter int unsigned SETTLE_FRAMES = 30,
  parameter int unsigned TURN_FRAMES   = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic       ang_up,
  input  logic       ang_dn,
  input  logic       pow_up,
  input  logic       pow_dn,
  input  logic [9:0] tankX0,
  input  logic [9:0] tankY0,
  input  logic [9:0] tankX1,
  input  logic [9:0] tankY1,
  input  logic       exploded,
  output logic       launch,
  output logic [9:0] launchX,
  output logic [9:0] launchY,
  output logic [3:0] angle,
  output logic [2:0] power,
  output logic       turn,
  output logic       busy,
  output logic [9:0] timer
);

  localparam int unsigned CNT_MAX = (ARM_TIMEOUT > SETTLE_FRAMES) ? ARM_TIMEOUT : SETTLE_FRAMES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  logic [2:0]    r_fs;
  logic          r_fire_q;
  state_t        r_state;
  logic          r_launch;
  logic [9:0]    r_lx;
  logic [9:0]    r_ly;
  logic          r_turn;
  logic [CW-1:0] r_fcnt;
  logic [3:0]    r_ang [2];
  logic [2:0]    r_pow [2];

  state_t     w_state_nxt;
  logic       w_tick;
  logic       w_aim;
  logic       w_auto;
  logic       w_fire_go;
  logic       w_step_en;
  logic       w_launch_set;
  logic       w_launch_clr;
  logic       w_latch;
  logic       w_swap;
  logic       w_cnt_clr;
  logic       w_cnt_inc;
  logic [3:0] w_ang_cur;
  logic [3:0] w_pow_cur;
  logic       w_ang_load;
  logic       w_pow_load;
  logic [3:0] w_ang_next;
  logic [3:0] w_pow_next;
  logic       w_unused;

  // r_fs[1:0] is the synchroniser, r_fs[2] the delayed copy for edge detect.
  assign w_tick    = r_fs[1] & ~r_fs[2];
  assign w_aim     = (r_state == AIM);
  assign w_fire_go = w_aim & ((fire & ~r_fire_q) | w_auto);
  // A fire in the same cycle as a step edge suppresses the step.
  assign w_step_en = w_aim & ~w_fire_go;

  assign w_ang_cur = r_ang[r_turn];
  assign w_pow_cur = {1'b0, r_pow[r_turn]};

  assign launch  = r_launch;
  assign launchX = r_lx;
  assign launchY = r_ly;
  assign angle   = w_ang_cur;
  assign power   = w_pow_cur[2:0];
  assign turn    = r_turn;
  assign busy    = ~w_aim;

  aim_stepper #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_ang_step (
    .clk    (clk),
    .reset  (reset),
    .i_up   (ang_up),
    .i_dn   (ang_dn),
    .i_tick (w_tick),
    .i_en   (w_step_en),
    .i_max  (ANGLE_MAX),
    .i_cur  (w_ang_cur),
    .o_load (w_ang_load),
    .o_next (w_ang_next)
  );

  aim_stepper #(.REPEAT_FRAMES(REPEAT_FRAMES)) u_pow_step (
    .clk    (clk),
    .reset  (reset),
    .i_up   (pow_up),
    .i_dn   (pow_dn),
    .i_tick (w_tick),
    .i_en   (w_step_en),
    .i_max  (POWER_MAX),
    .i_cur  (w_pow_cur),
    .o_load (w_pow_load),
    .o_next (w_pow_next)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_launch_set = 1'b0;
    w_launch_clr = 1'b0;
    w_latch      = 1'b0;
    w_swap       = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      AIM: begin
        if (w_fire_go) begin
          w_latch     = 1'b1;
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        if (w_tick) begin
          if (!r_launch) begin
            w_launch_set = 1'b1;
          end else begin
            w_launch_clr = 1'b1;
            w_cnt_clr    = 1'b1;
            w_state_nxt  = ARM;
          end
        end
      end
      ARM: begin
        if (!exploded) begin
          w_state_nxt = FLIGHT;
        end else if (w_tick) begin
          if (r_fcnt == CW'(ARM_TIMEOUT - 1)) w_state_nxt = AIM;
          else                                w_cnt_inc   = 1'b1;
        end
      end
      FLIGHT: begin
        if (exploded) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (w_tick) begin
          if (r_fcnt == CW'(SETTLE_FRAMES - 1)) begin
            w_swap      = 1'b1;
            w_state_nxt = AIM;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      default: w_state_nxt = AIM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fs     <= '0;
      r_fire_q <= 1'b0;
      r_state  <= AIM;
      r_launch <= 1'b0;
      r_lx     <= '0;
      r_ly     <= '0;
      r_turn   <= 1'b0;
      r_fcnt   <= '0;
      r_ang[0] <= P0_ANGLE;
      r_ang[1] <= P1_ANGLE;
      r_pow[0] <= P0_POWER[2:0];
      r_pow[1] <= P1_POWER[2:0];
    end else begin
      r_fs     <= {r_fs[1:0], frame_clk};
      r_fire_q <= fire;
      r_state  <= w_state_nxt;
      if (w_launch_set)      r_launch <= 1'b1;
      else if (w_launch_clr) r_launch <= 1'b0;
      if (w_latch) begin
        r_lx <= r_turn ? tankX1 : tankX0;
        r_ly <= r_turn ? tankY1 : tankY0;
      end
      if (w_swap) r_turn <= ~r_turn;
      if (w_cnt_clr)      r_fcnt <= '0;
      else if (w_cnt_inc) r_fcnt <= r_fcnt + 1'b1;
      if (w_ang_load) r_ang[r_turn] <= w_ang_next;
      if (w_pow_load) r_pow[r_turn] <= w_pow_next[2:0];
    end
  end

`ifdef TURN_TIMER_EN
  logic [9:0] r_timer;

  assign w_auto   = (r_timer == '0);
  assign timer    = r_timer;
  assign w_unused = w_pow_next[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= 10'(TURN_FRAMES);
    end else if ((w_state_nxt == AIM) && !w_aim) begin
      r_timer <= 10'(TURN_FRAMES);
    end else if (w_aim && w_tick && (r_timer != '0)) begin
      r_timer <= r_timer - 10'd1;
    end
  end
`else
  assign w_auto   = 1'b0;
  assign timer    = '0;
  assign w_unused = w_pow_next[3] ^ (^10'(TURN_FRAMES));
`endif

endmodule

// File: tb/tb_turn_launcher.sv
module tb_turn_launcher;

  localparam int RPT    = 8;
  localparam int ARMTO  = 4;
  localparam int SETTLE = 30;

  localparam int PH_AIM    = 0;
  localparam int PH_LAUNCH = 1;
  localparam int PH_ARM    = 2;
  localparam int PH_FLIGHT = 3;
  localparam int PH_SETTLE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       fire = 1'b0;
  logic       ang_up = 1'b0, ang_dn = 1'b0, pow_up = 1'b0, pow_dn = 1'b0;
  logic [9:0] tankX0 = 10'd0, tankY0 = 10'd0, tankX1 = 10'd0, tankY1 = 10'd0;
  logic       exploded = 1'b1;
  logic       launch;
  logic [9:0] launchX, launchY;
  logic [3:0] angle;
  logic [2:0] power;
  logic       turn, busy;
  logic [9:0] timer;

  turn_launcher #(
    .REPEAT_FRAMES(RPT),
    .ARM_TIMEOUT  (ARMTO),
    .SETTLE_FRAMES(SETTLE),
    .TURN_FRAMES  (600)
  ) dut (
    .clk(clk), .reset(reset), .frame_clk(frame_clk), .fire(fire),
    .ang_up(ang_up), .ang_dn(ang_dn), .pow_up(pow_up), .pow_dn(pow_dn),
    .tankX0(tankX0), .tankY0(tankY0), .tankX1(tankX1), .tankY1(tankY1),
    .exploded(exploded), .launch(launch), .launchX(launchX), .launchY(launchY),
    .angle(angle), .power(power), .turn(turn), .busy(busy), .timer(timer)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit meaningful = 1'b0;
  int launch_edges = 0;

  // Behavioural model: phase plus per-phase tick counts, per-player aim.
  int m_ang[2];
  int m_pow[2];
  int m_turn, m_phase, m_launch, m_lx, m_ly, arm_n, set_n;
  bit valid[4];
  int n[4];

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endfunction

  function automatic int sat(input int v, input int mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  function automatic void model_reset();
    m_ang[0] = 2; m_ang[1] = 6;
    m_pow[0] = 4; m_pow[1] = 4;
    m_turn = 0; m_phase = PH_AIM; m_launch = 0; m_lx = 0; m_ly = 0;
    arm_n = 0; set_n = 0;
    for (int b = 0; b < 4; b++) begin valid[b] = 1'b0; n[b] = 0; end
  endfunction

  function automatic void model_tick();
    int st[4];
    case (m_phase)
      PH_AIM: begin
        for (int b = 0; b < 4; b++) begin
          st[b] = 0;
          if (valid[b]) begin
            n[b]++;
            if ((n[b] == 1) || (((n[b] - 1) % RPT) == 0)) st[b] = 1;
          end
        end
        m_ang[m_turn] = sat(m_ang[m_turn] + st[0] - st[1], 8);
        m_pow[m_turn] = sat(m_pow[m_turn] + st[2] - st[3], 7);
      end
      PH_LAUNCH: begin
        if (m_launch == 0) m_launch = 1;
        else begin
          m_launch = 0;
          m_phase  = exploded ? PH_ARM : PH_FLIGHT;
          arm_n    = 0;
        end
      end
      PH_ARM: begin
        arm_n++;
        if (arm_n == ARMTO) m_phase = PH_AIM;
      end
      PH_SETTLE: begin
        set_n++;
        if (set_n == SETTLE) begin
          m_phase = PH_AIM;
          m_turn  = 1 - m_turn;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic void model_fire();
    if (m_phase == PH_AIM) begin
      m_lx = (m_turn == 1) ? int'(tankX1) : int'(tankX0);
      m_ly = (m_turn == 1) ? int'(tankY1) : int'(tankY0);
      m_phase = PH_LAUNCH;
      for (int b = 0; b < 4; b++) begin valid[b] = 1'b0; n[b] = 0; end
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (meaningful) begin
      chk("cmp_angle",   int'(angle),   m_ang[m_turn]);
      chk("cmp_power",   int'(power),   m_pow[m_turn]);
      chk("cmp_turn",    int'(turn),    m_turn);
      chk("cmp_busy",    int'(busy),    (m_phase != PH_AIM) ? 1 : 0);
      chk("cmp_launch",  int'(launch),  m_launch);
      chk("cmp_launchX", int'(launchX), m_lx);
      chk("cmp_launchY", int'(launchY), m_ly);
`ifndef TURN_TIMER_EN
      chk("cmp_timer",   int'(timer),   0);
`endif
    end
  end

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       ang_up = v;
      1:       ang_dn = v;
      2:       pow_up = v;
      default: pow_dn = v;
    endcase
  endtask

  task automatic ev_begin();
    @(negedge clk);
    meaningful = 1'b0;
  endtask

  task automatic ev_end();
    repeat (3) @(negedge clk);
    meaningful = 1'b1;
  endtask

  task automatic tick_frame();
    @(negedge clk);
    meaningful = 1'b0;
    if (launch) launch_edges++;
    frame_clk = 1'b1;
    repeat (4) @(negedge clk);
    model_tick();
    meaningful = 1'b1;
    repeat (2) @(negedge clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick_frame();
  endtask

  task automatic press(input int b);
    ev_begin();
    set_btn(b, 1'b1);
    if (m_phase == PH_AIM) begin valid[b] = 1'b1; n[b] = 0; end
    ev_end();
  endtask

  task automatic release_btn(input int b);
    ev_begin();
    set_btn(b, 1'b0);
    valid[b] = 1'b0; n[b] = 0;
    ev_end();
  endtask

  task automatic fire_pulse();
    ev_begin(); fire = 1'b1; model_fire(); ev_end();
    ev_begin(); fire = 1'b0; ev_end();
  endtask

  task automatic set_exploded(input logic v);
    ev_begin();
    exploded = v;
    if ((m_phase == PH_ARM) && !v) m_phase = PH_FLIGHT;
    else if ((m_phase == PH_FLIGHT) && v) begin m_phase = PH_SETTLE; set_n = 0; end
    ev_end();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_angle",  int'(angle), 2);
    chk("rst_power",  int'(power), 4);
    chk("rst_turn",   int'(turn), 0);
    chk("rst_busy",   int'(busy), 0);
    chk("rst_launch", int'(launch), 0);
    chk("rst_launchX", int'(launchX), 0);
    chk("rst_timer",  int'(timer), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    meaningful = 1'b1;

    // Hold ang_up: press step, then every RPT ticks, saturating at 8.
    press(0);
    for (int i = 1; i <= 50; i++) begin
      tick_frame();
      if (i == 1)  chk("rep_tick1",  int'(angle), 3);
      if (i == 8)  chk("rep_tick8",  int'(angle), 3);
      if (i == 9)  chk("rep_tick9",  int'(angle), 4);
      if (i == 17) chk("rep_tick17", int'(angle), 5);
    end
    chk("ang_sat_hi", int'(angle), 8);
    release_btn(0);

    press(1); ticks(2); release_btn(1);
    chk("ang_dn_one", int'(angle), 7);

    // Up and down together cancel, including on repeat ticks.
    ev_begin();
    ang_up = 1'b1; ang_dn = 1'b1;
    valid[0] = 1'b1; valid[1] = 1'b1; n[0] = 0; n[1] = 0;
    ev_end();
    ticks(10);
    chk("ang_both", int'(angle), 7);
    release_btn(0); release_btn(1);

    press(2);
    for (int i = 1; i <= 20; i++) begin
      tick_frame();
      if (i == 17) chk("pow_tick17", int'(power), 7);
    end
    chk("pow_sat_hi", int'(power), 7);
    release_btn(2);
    press(3); ticks(1); release_btn(3);
    chk("pow_dn_one", int'(power), 6);

    // Fire together with a step edge: fire wins, step dropped.
    tankX0 = 10'd100; tankY0 = 10'd300; tankX1 = 10'd700; tankY1 = 10'd50;
    ev_begin();
    pow_up = 1'b1; valid[2] = 1'b1; n[2] = 0;
    fire = 1'b1; model_fire();
    ev_end();
    chk("fire_lx",   int'(launchX), 100);
    chk("fire_ly",   int'(launchY), 300);
    chk("fire_busy", int'(busy), 1);
    chk("fire_nolaunch", int'(launch), 0);
    launch_edges = 0;
    tick_frame();
    chk("launch_hi", int'(launch), 1);
    tick_frame();
    chk("launch_lo", int'(launch), 0);
    chk("launch_edges", launch_edges, 1);
    chk("fire_drops_step", int'(power), 6);
    release_btn(2);
    ev_begin(); fire = 1'b0; ev_end();

    // Full flight: ARM -> FLIGHT -> SETTLE -> swap.
    ticks(1);
    set_exploded(1'b0);
    fire_pulse();
    ticks(38);
    set_exploded(1'b1);
    ticks(29);
    chk("settle_29_turn", int'(turn), 0);
    chk("settle_29_busy", int'(busy), 1);
    ticks(1);
    chk("swap_turn",  int'(turn), 1);
    chk("swap_angle", int'(angle), 6);
    chk("swap_power", int'(power), 4);
    chk("swap_busy",  int'(busy), 0);

    // ARM timeout with exploded held high: no swap.
    fire_pulse();
    chk("p1_lx", int'(launchX), 700);
    chk("p1_ly", int'(launchY), 50);
    ticks(2);
    ticks(3);
    chk("arm_3_busy", int'(busy), 1);
    ticks(1);
    chk("arm_to_busy", int'(busy), 0);
    chk("arm_to_turn", int'(turn), 1);

    // Player 1 aims, fires, then reset asynchronously mid-flight.
    press(1); ticks(1); release_btn(1);
    chk("p1_ang_dn", int'(angle), 5);
    fire_pulse();
    ticks(2);
    set_exploded(1'b0);
    ticks(3);
    chk("flight_busy", int'(busy), 1);
    meaningful = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_launch", int'(launch), 0);
    chk("arst_busy",   int'(busy), 0);
    chk("arst_turn",   int'(turn), 0);
    chk("arst_angle",  int'(angle), 2);
    chk("arst_power",  int'(power), 4);
    chk("arst_lx",     int'(launchX), 0);
    chk("arst_ly",     int'(launchY), 0);
    model_reset();
    exploded = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    meaningful = 1'b1;

    press(2); ticks(2); release_btn(2);
    chk("post_rst_pow", int'(power), 5);

    meaningful = 1'b0;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
